// File: rtl/varredor_tiros_if.sv
// Memory-side bus of the shot sweeper: shared address, registered
// read data from both memories and the load-flag write port.
interface varredor_tiros_if #(
    parameter int ADDR_W = 4,
    parameter int COOR_W = 4
);
    logic [ADDR_W-1:0]   mem_addr;
    logic [2*COOR_W+1:0] mem_q_tiro;
    logic                mem_q_loaded;
    logic                mem_load_we;
    logic                mem_load_data;

    modport master (
        output mem_addr,
        output mem_load_we,
        output mem_load_data,
        input  mem_q_tiro,
        input  mem_q_loaded
    );

    modport slave (
        input  mem_addr,
        input  mem_load_we,
        input  mem_load_data,
        output mem_q_tiro,
        output mem_q_loaded
    );
endinterface

// File: rtl/varredor_tiros.sv
// Shot-table collision sweeper: finds the lowest loaded shot on the
// asteroid coordinate, counts loaded shots and unloads the hit shot.
module varredor_tiros #(
    parameter int N_TIROS = 16,
    parameter int ADDR_W  = 4,
    parameter int COOR_W  = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                iniciar,
    input  logic [COOR_W-1:0]   aste_coor_x,
    input  logic [COOR_W-1:0]   aste_coor_y,
    varredor_tiros_if.master    mem,
    output logic                ocupado,
    output logic                pronto,
    output logic                colisao,
    output logic [ADDR_W-1:0]   indice_colisao,
    output logic [1:0]          opcode_colisao,
    output logic [ADDR_W:0]     n_ativos
);
    localparam logic [2:0] OCIOSO = 3'd0;
    localparam logic [2:0] VARRE  = 3'd1;
    localparam logic [2:0] DRENA  = 3'd2;
    localparam logic [2:0] APAGA  = 3'd3;
    localparam logic [2:0] FIM    = 3'd4;

    localparam logic [ADDR_W-1:0] UM     = 1;
    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_TIROS - 1);
    localparam logic [ADDR_W:0]   UM_N   = 1;

    logic [2:0]        r_estado;
    logic [2:0]        w_prox;
    logic [ADDR_W-1:0] r_idx;
    logic [COOR_W-1:0] r_x;
    logic [COOR_W-1:0] r_y;
    logic              r_colisao;
    logic [ADDR_W-1:0] r_indice;
    logic [1:0]        r_opcode;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W-1:0] w_addr;

    logic [COOR_W-1:0] w_tx;
    logic [COOR_W-1:0] w_ty;
    logic [1:0]        w_top;
    logic [ADDR_W-1:0] w_idx_aval;
    logic              w_avalia;
    logic              w_ld;
    logic              w_hit;

    assign w_tx  = mem.mem_q_tiro[2*COOR_W+1 -: COOR_W];
    assign w_ty  = mem.mem_q_tiro[COOR_W+1 -: COOR_W];
    assign w_top = mem.mem_q_tiro[1:0];

    // idx wraps to 0 after the last address, so idx-1 also names
    // the last entry while draining.
    assign w_idx_aval = r_idx - UM;
    assign w_avalia   = (r_estado == VARRE && r_idx != '0)
                      || r_estado == DRENA;
    assign w_ld  = w_avalia && mem.mem_q_loaded;
    assign w_hit = w_ld && !r_colisao
                 && w_tx == r_x && w_ty == r_y;

    always_comb begin
        w_prox = r_estado;
        unique case (r_estado)
            OCIOSO: if (iniciar) w_prox = VARRE;
            VARRE:  if (r_idx == ULTIMO) w_prox = DRENA;
            DRENA:  w_prox = (r_colisao || w_hit) ? APAGA : FIM;
            APAGA:  w_prox = FIM;
            FIM:    w_prox = OCIOSO;
            default: w_prox = OCIOSO;
        endcase
    end

    always_comb begin
        w_addr = '0;
        unique case (1'b1)
            r_estado == VARRE: w_addr = r_idx;
            r_estado == APAGA: w_addr = r_indice;
            default:           w_addr = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado  <= OCIOSO;
            r_idx     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colisao <= 1'b0;
            r_indice  <= '0;
            r_opcode  <= '0;
            r_n       <= '0;
        end else begin
            r_estado <= w_prox;
            if (r_estado == OCIOSO && iniciar) begin
                r_x       <= aste_coor_x;
                r_y       <= aste_coor_y;
                r_colisao <= 1'b0;
                r_indice  <= '0;
                r_opcode  <= '0;
                r_n       <= '0;
                r_idx     <= '0;
            end else begin
                if (r_estado == VARRE) r_idx <= r_idx + UM;
                if (w_ld) r_n <= r_n + UM_N;
                if (w_hit) begin
                    r_colisao <= 1'b1;
                    r_indice  <= w_idx_aval;
                    r_opcode  <= w_top;
                end
            end
        end
    end

    assign mem.mem_addr      = w_addr;
    assign mem.mem_load_we   = (r_estado == APAGA);
    assign mem.mem_load_data = 1'b0;

    assign ocupado        = (r_estado != OCIOSO);
    assign pronto         = (r_estado == FIM);
    assign colisao        = r_colisao;
    assign indice_colisao = r_indice;
    assign opcode_colisao = r_opcode;
    assign n_ativos       = r_n;
endmodule

// File: tb/tb_varredor_tiros.sv
// Bench for varredor_tiros: behavioural shot memories plus a
// scoreboard of expected sweep results.
module tb_varredor_tiros;
    localparam int N  = 16;
    localparam int AW = 4;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic iniciar = 1'b1;
    logic [CW-1:0] ax = '0;
    logic [CW-1:0] ay = '0;
    logic ocupado, pronto, colisao;
    logic [AW-1:0] indice_colisao;
    logic [1:0] opcode_colisao;
    logic [AW:0] n_ativos;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    varredor_tiros_if #(.ADDR_W(AW), .COOR_W(CW)) bus ();

    varredor_tiros #(.N_TIROS(N), .ADDR_W(AW), .COOR_W(CW)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .iniciar        (iniciar),
        .aste_coor_x    (ax),
        .aste_coor_y    (ay),
        .mem            (bus.master),
        .ocupado        (ocupado),
        .pronto         (pronto),
        .colisao        (colisao),
        .indice_colisao (indice_colisao),
        .opcode_colisao (opcode_colisao),
        .n_ativos       (n_ativos)
    );

    // Shot memories; a flag counts as cleared when written in the
    // current table epoch.
    logic [2*CW+1:0] tiro [N];
    logic ld_init [N];
    int clr_epoch [N] = '{default: -1};
    int epoch = 0;
    int wr_count = 0;
    logic [AW-1:0] wr_addr = '0;
    logic wr_data = 1'b0;

    always @(posedge clock) begin
        bus.mem_q_tiro   <= tiro[bus.mem_addr];
        bus.mem_q_loaded <= ld_init[bus.mem_addr]
                         && (clr_epoch[bus.mem_addr] != epoch);
        if (bus.mem_load_we) begin
            if (bus.mem_load_data == 1'b0)
                clr_epoch[bus.mem_addr] <= epoch;
            wr_count <= wr_count + 1;
            wr_addr  <= bus.mem_addr;
            wr_data  <= bus.mem_load_data;
        end
    end

    function automatic logic eff(input int i);
        return ld_init[i] && (clr_epoch[i] != epoch);
    endfunction

    typedef struct {
        logic          col;
        logic [AW-1:0] idx;
        logic [1:0]    op;
        logic [AW:0]   n;
    } exp_t;

    exp_t sb[$];

    task automatic clear_table();
        epoch = epoch + 1;
        for (int i = 0; i < N; i++) begin
            tiro[i] = '0;
            ld_init[i] = 1'b0;
        end
    endtask

    task automatic set_entry(input int i, input logic [CW-1:0] x,
                             input logic [CW-1:0] y,
                             input logic [1:0] op, input logic ld);
        tiro[i] = {x, y, op};
        ld_init[i] = ld;
    endtask

    task automatic run_sweep(input logic [CW-1:0] x,
                             input logic [CW-1:0] y,
                             input int busy_at,
                             output int lat, output int nwr);
        exp_t e;
        exp_t g;
        int w0;
        e.col = 1'b0; e.idx = '0; e.op = '0; e.n = '0;
        for (int i = 0; i < N; i++) begin
            if (eff(i)) begin
                e.n = e.n + 1'b1;
                if (!e.col && tiro[i][2*CW+1 -: CW] == x
                    && tiro[i][CW+1 -: CW] == y) begin
                    e.col = 1'b1;
                    e.idx = AW'(i);
                    e.op  = tiro[i][1:0];
                end
            end
        end
        sb.push_back(e);
        w0 = wr_count;
        ax = x; ay = y; iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        lat = 1;
        while (!pronto && lat < 40) begin
            if (lat == busy_at) begin
                iniciar = 1'b1; ax = ~x; ay = ~y;
            end else begin
                iniciar = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        iniciar = 1'b0;
        nwr = wr_count - w0;
        g = sb.pop_front();
        checks++;
        if (!pronto) begin
            errors++;
            $display("FAIL pronto_timeout got 0 want 1");
        end else if (colisao !== g.col || indice_colisao !== g.idx
                     || opcode_colisao !== g.op || n_ativos !== g.n) begin
            errors++;
            $display("FAIL result got col=%0d idx=%0d op=%0d n=%0d want col=%0d idx=%0d op=%0d n=%0d",
                     colisao, indice_colisao, opcode_colisao, n_ativos,
                     g.col, g.idx, g.op, g.n);
        end
    endtask

    task automatic test_reset();
        int lat, nwr;
        clear_table();
        ax = 4'd5; ay = 4'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if ({ocupado, pronto, colisao, indice_colisao, opcode_colisao,
                 n_ativos, bus.mem_load_we, bus.mem_addr} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got ocupado=%0d we=%0d addr=%0d want 0",
                         ocupado, bus.mem_load_we, bus.mem_addr);
            end
        end
        reset_n = 1'b1;
        run_sweep(4'd5, 4'd5, 0, lat, nwr);
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL reset_release_latency got %0d want 18", lat);
        end
    endtask

    task automatic test_empty();
        int lat, nwr;
        clear_table();
        run_sweep(4'd5, 4'd5, 0, lat, nwr);
        checks++;
        if (lat !== 18 || nwr !== 0) begin
            errors++;
            $display("FAIL empty got lat=%0d wr=%0d want lat=18 wr=0", lat, nwr);
        end
    endtask

    task automatic test_single_hit();
        int lat, nwr;
        clear_table();
        set_entry(7, 4'd5, 4'd5, 2'd2, 1'b1);
        set_entry(8, 4'd5, 4'd5, 2'd1, 1'b0);
        run_sweep(4'd5, 4'd5, 0, lat, nwr);
        checks++;
        if (lat !== 19 || nwr !== 1 || wr_addr !== 4'd7 || wr_data !== 1'b0) begin
            errors++;
            $display("FAIL single_hit got lat=%0d wr=%0d addr=%0d data=%0d want 19 1 7 0",
                     lat, nwr, wr_addr, wr_data);
        end
        @(negedge clock);
        checks++;
        if (ocupado !== 1'b0 || colisao !== 1'b1 || indice_colisao !== 4'd7) begin
            errors++;
            $display("FAIL hold got ocupado=%0d col=%0d idx=%0d want 0 1 7",
                     ocupado, colisao, indice_colisao);
        end
    endtask

    task automatic test_priority();
        int lat, nwr;
        clear_table();
        set_entry(0, 4'd1, 4'd1, 2'd0, 1'b1);
        set_entry(3, 4'd5, 4'd5, 2'd3, 1'b1);
        set_entry(9, 4'd1, 4'd1, 2'd1, 1'b1);
        set_entry(12, 4'd5, 4'd5, 2'd1, 1'b1);
        set_entry(6, 4'd5, 4'd4, 2'd0, 1'b1);
        set_entry(6, 4'd5, 4'd4, 2'd0, 1'b0);
        run_sweep(4'd5, 4'd5, 0, lat, nwr);
        checks++;
        if (nwr !== 1 || wr_addr !== 4'd3 || eff(3) !== 1'b0 || eff(12) !== 1'b1) begin
            errors++;
            $display("FAIL priority_clear got wr=%0d addr=%0d f3=%0d f12=%0d want 1 3 0 1",
                     nwr, wr_addr, eff(3), eff(12));
        end
        @(negedge clock);
        run_sweep(4'd5, 4'd5, 0, lat, nwr);
        checks++;
        if (nwr !== 1 || wr_addr !== 4'd12 || lat !== 19) begin
            errors++;
            $display("FAIL priority_second got wr=%0d addr=%0d lat=%0d want 1 12 19",
                     nwr, wr_addr, lat);
        end
    endtask

    task automatic test_boundary();
        int lat, nwr;
        clear_table();
        set_entry(0, 4'd5, 4'd5, 2'd1, 1'b0);
        set_entry(15, 4'd5, 4'd5, 2'd3, 1'b1);
        run_sweep(4'd5, 4'd5, 0, lat, nwr);
        checks++;
        if (lat !== 19 || nwr !== 1 || wr_addr !== 4'd15) begin
            errors++;
            $display("FAIL boundary_last got lat=%0d wr=%0d addr=%0d want 19 1 15",
                     lat, nwr, wr_addr);
        end
        @(negedge clock);
        clear_table();
        set_entry(0, 4'hF, 4'h0, 2'd2, 1'b1);
        set_entry(5, 4'hF, 4'h1, 2'd1, 1'b1);
        run_sweep(4'hF, 4'h0, 0, lat, nwr);
        checks++;
        if (nwr !== 1 || wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL boundary_first got wr=%0d addr=%0d want 1 0", nwr, wr_addr);
        end
    endtask

    task automatic test_busy_and_reset();
        int lat, nwr, w0;
        clear_table();
        set_entry(2, 4'd10, 4'd10, 2'd1, 1'b1);
        set_entry(7, 4'd5, 4'd5, 2'd2, 1'b1);
        run_sweep(4'd5, 4'd5, 5, lat, nwr);
        checks++;
        if (lat !== 19 || wr_addr !== 4'd7) begin
            errors++;
            $display("FAIL busy_ignored got lat=%0d addr=%0d want 19 7", lat, wr_addr);
        end
        @(negedge clock);
        clear_table();
        set_entry(7, 4'd5, 4'd5, 2'd2, 1'b1);
        w0 = wr_count;
        ax = 4'd5; ay = 4'd5; iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ocupado, pronto, colisao, indice_colisao, opcode_colisao,
             n_ativos, bus.mem_load_we, bus.mem_addr} !== '0) begin
            errors++;
            $display("FAIL midsweep_reset got ocupado=%0d col=%0d idx=%0d n=%0d want 0",
                     ocupado, colisao, indice_colisao, n_ativos);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (wr_count !== w0 || eff(7) !== 1'b1 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_write got wr=%0d f7=%0d want 0 1",
                     wr_count - w0, eff(7));
        end
        reset_n = 1'b1;
        @(negedge clock);
        run_sweep(4'd5, 4'd5, 0, lat, nwr);
        checks++;
        if (lat !== 19 || nwr !== 1 || wr_addr !== 4'd7) begin
            errors++;
            $display("FAIL after_reset got lat=%0d wr=%0d addr=%0d want 19 1 7",
                     lat, nwr, wr_addr);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clock);
        test_empty();
        @(negedge clock);
        test_single_hit();
        @(negedge clock);
        test_priority();
        @(negedge clock);
        test_boundary();
        @(negedge clock);
        test_busy_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
